// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and entry type for the register-file writeback arbiter.
package wb_pkg;

  localparam int unsigned WB_AW = 5;
  localparam int unsigned WB_DW = 32;

  localparam logic [4:0]  REG_ZERO         = 5'd0;
  localparam int unsigned DEFAULT_WB_DEPTH = 4;

  typedef struct packed {
    logic             live;
    logic [WB_AW-1:0] rw;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the pipeline/auxiliary sources and the register-file write port.
interface regfile_wb_arbiter_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
);

  logic          PipeWr;
  logic [AW-1:0] PipeRW;
  logic [DW-1:0] PipeBusW;
  logic          AuxValid;
  logic [AW-1:0] AuxRW;
  logic [DW-1:0] AuxData;
  logic          AuxReady;
  logic          RegWr;
  logic [AW-1:0] RW;
  logic [DW-1:0] BusW;
  logic [31:0]   PendMask;

  modport slave (
    input  PipeWr, PipeRW, PipeBusW, AuxValid, AuxRW, AuxData,
    output AuxReady, RegWr, RW, BusW, PendMask
  );

  modport master (
    output PipeWr, PipeRW, PipeBusW, AuxValid, AuxRW, AuxData,
    input  AuxReady, RegWr, RW, BusW, PendMask
  );

endinterface

// File: rtl/regfile_wb_arbiter_kill_fifo.sv
// Circular FIFO of auxiliary writebacks with per-entry live bit and kill-by-address.
module wb_kill_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_WB_DEPTH,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       push_live,
  input  logic [AW-1:0]              push_rw,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  input  logic                       kill_en,
  input  logic [AW-1:0]              kill_rw,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       head_live,
  output logic [AW-1:0]              head_rw,
  output logic [DW-1:0]              head_data,
  output logic [31:0]                pend_mask
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] live_q;
  logic [DEPTH-1:0] live_n;
  logic [AW-1:0]    rw_q   [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [31:0]      mask_n;
  logic [AW-1:0]    rw_sel;

  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign head_live = live_q[rd_ptr];
  assign head_rw   = rw_q[rd_ptr];
  assign head_data = data_q[rd_ptr];

  // Mask is built from the post-edge queue so it tracks push/pop/kill one cycle later.
  always_comb begin
    live_n = live_q;
    mask_n = '0;
    rw_sel = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (kill_en && rw_q[i] == kill_rw) live_n[i] = 1'b0;
    end
    if (pop)  live_n[rd_ptr] = 1'b0;
    if (push) live_n[wr_ptr] = push_live;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rw_sel = (push && PW'(i) == wr_ptr) ? push_rw : rw_q[i];
      if (live_n[i]) mask_n[rw_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      live_q    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      pend_mask <= '0;
    end else begin
      live_q    <= live_n;
      pend_mask <= mask_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rw_q[wr_ptr]   <= push_rw;
      data_q[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, aux results are queued.
// Optional macro WB_AUX_BYPASS_EN sends an aux write straight out when the queue is empty.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_WB_DEPTH,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input logic                 Clk,
  input logic                 Rst,
  regfile_wb_arbiter_if.slave wb
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [CW-1:0] count;
  logic          fifo_empty;
  logic          head_live;
  logic [AW-1:0] head_rw;
  logic [DW-1:0] head_data;
  logic [31:0]   pend_mask;

  logic pipe_go, aux_ready, aux_xfer, aux_nz, bypass, push, push_live, pop;

  logic          reg_wr_q;
  logic [AW-1:0] rw_q;
  logic [DW-1:0] busw_q;

  always_comb begin
    pipe_go   = wb.PipeWr && (wb.PipeRW != AW'(REG_ZERO));
    aux_ready = !Rst && (count < CW'(DEPTH));
    aux_xfer  = wb.AuxValid && aux_ready;
    aux_nz    = (wb.AuxRW != AW'(REG_ZERO));
`ifdef WB_AUX_BYPASS_EN
    bypass    = fifo_empty && !pipe_go && aux_xfer && aux_nz;
`else
    bypass    = 1'b0;
`endif
    push      = aux_xfer && aux_nz && !bypass;
    // Aux results are older than a same-cycle pipeline write to the same register.
    push_live = !(pipe_go && wb.AuxRW == wb.PipeRW);
    pop       = !pipe_go && !fifo_empty;
  end

  wb_kill_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) u_fifo (
    .clk      (Clk),
    .rst      (Rst),
    .push     (push),
    .push_live(push_live),
    .push_rw  (wb.AuxRW),
    .push_data(wb.AuxData),
    .pop      (pop),
    .kill_en  (pipe_go),
    .kill_rw  (wb.PipeRW),
    .count    (count),
    .empty    (fifo_empty),
    .head_live(head_live),
    .head_rw  (head_rw),
    .head_data(head_data),
    .pend_mask(pend_mask)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      reg_wr_q <= 1'b0;
      rw_q     <= '0;
      busw_q   <= '0;
    end else if (pipe_go) begin
      reg_wr_q <= 1'b1;
      rw_q     <= wb.PipeRW;
      busw_q   <= wb.PipeBusW;
    end else if (bypass) begin
      reg_wr_q <= 1'b1;
      rw_q     <= wb.AuxRW;
      busw_q   <= wb.AuxData;
    end else if (pop) begin
      reg_wr_q <= head_live;
      if (head_live) begin
        rw_q   <= head_rw;
        busw_q <= head_data;
      end
    end else begin
      reg_wr_q <= 1'b0;
    end
  end

  assign wb.AuxReady = aux_ready;
  assign wb.RegWr    = reg_wr_q;
  assign wb.RW       = rw_q;
  assign wb.BusW     = busw_q;
  assign wb.PendMask = pend_mask;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed table, corner sequences and random traffic vs a queue model.
module tb_regfile_wb_arbiter;
  import wb_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.AW(5), .DW(32)) wb ();

  regfile_wb_arbiter #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .Clk(clk),
    .Rst(rst),
    .wb (wb)
  );

  int total = 0;
  int bad   = 0;

  wb_entry_t q[$];

  logic        m_ready, m_regwr;
  logic [4:0]  m_rw = 5'd0;
  logic [31:0] m_busw = 32'd0;
  logic [31:0] m_pend;
  logic        o_ready, o_regwr;
  logic [4:0]  o_rw;
  logic [31:0] o_busw, o_pend;

  typedef struct {
    logic        r;
    logic        pw;
    logic [4:0]  prw;
    logic [31:0] pd;
    logic        av;
    logic [4:0]  arw;
    logic [31:0] ad;
    logic        e_ready;
    logic        e_regwr;
    logic        e_bus;
    logic [4:0]  e_rw;
    logic [31:0] e_busw;
    logic [31:0] e_pend;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t v(
    input logic r, input logic pw, input logic [4:0] prw, input logic [31:0] pd,
    input logic av, input logic [4:0] arw, input logic [31:0] ad,
    input logic e_ready, input logic e_regwr, input logic e_bus,
    input logic [4:0] e_rw, input logic [31:0] e_busw, input logic [31:0] e_pend);
    vec_t t;
    t.r = r; t.pw = pw; t.prw = prw; t.pd = pd; t.av = av; t.arw = arw; t.ad = ad;
    t.e_ready = e_ready; t.e_regwr = e_regwr; t.e_bus = e_bus;
    t.e_rw = e_rw; t.e_busw = e_busw; t.e_pend = e_pend;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, advance the queue model, and sample the registered outputs after the edge.
  task automatic apply(input logic r, input logic pw, input logic [4:0] prw, input logic [31:0] pd,
                       input logic av, input logic [4:0] arw, input logic [31:0] ad);
    logic go, xfer, byp;
    wb_entry_t e;
    rst = r;
    wb.PipeWr = pw; wb.PipeRW = prw; wb.PipeBusW = pd;
    wb.AuxValid = av; wb.AuxRW = arw; wb.AuxData = ad;
    #1;
    o_ready = wb.AuxReady;
    m_ready = !r && (q.size() < DEPTH);
    go   = pw && (prw != 5'd0);
    xfer = av && m_ready;
    byp  = 1'b0;
`ifdef WB_AUX_BYPASS_EN
    byp = (q.size() == 0) && !go && xfer && (arw != 5'd0);
`endif
    if (r) begin
      q.delete();
      m_regwr = 1'b0; m_rw = 5'd0; m_busw = 32'd0;
    end else begin
      if (go) begin
        foreach (q[i]) if (q[i].rw == prw) q[i].live = 1'b0;
        m_regwr = 1'b1; m_rw = prw; m_busw = pd;
      end else if (byp) begin
        m_regwr = 1'b1; m_rw = arw; m_busw = ad;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        m_regwr = e.live;
        if (e.live) begin m_rw = e.rw; m_busw = e.data; end
      end else begin
        m_regwr = 1'b0;
      end
      if (xfer && arw != 5'd0 && !byp) begin
        e.live = !(go && arw == prw); e.rw = arw; e.data = ad;
        q.push_back(e);
      end
    end
    m_pend = 32'd0;
    foreach (q[i]) if (q[i].live) m_pend[q[i].rw] = 1'b1;
    @(posedge clk);
    #1;
    o_regwr = wb.RegWr; o_rw = wb.RW; o_busw = wb.BusW; o_pend = wb.PendMask;
  endtask

  task automatic step(input string tag, input logic r, input logic pw, input logic [4:0] prw,
                      input logic [31:0] pd, input logic av, input logic [4:0] arw, input logic [31:0] ad);
    apply(r, pw, prw, pd, av, arw, ad);
    chk($sformatf("%s.ready", tag), 32'(o_ready), 32'(m_ready));
    chk($sformatf("%s.regwr", tag), 32'(o_regwr), 32'(m_regwr));
    if (m_regwr) begin
      chk($sformatf("%s.rw", tag), 32'(o_rw), 32'(m_rw));
      chk($sformatf("%s.busw", tag), o_busw, m_busw);
    end
    chk($sformatf("%s.pend", tag), o_pend, m_pend);
  endtask

  initial begin
    wb.PipeWr = 1'b0; wb.PipeRW = 5'd0; wb.PipeBusW = 32'd0;
    wb.AuxValid = 1'b0; wb.AuxRW = 5'd0; wb.AuxData = 32'd0;

    tbl[0]  = v(1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b1, 5'd0,  32'h0,        32'h0);
    tbl[1]  = v(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b0, 5'd0,  32'h0,        32'h0);
    tbl[2]  = v(1'b0, 1'b1, 5'd10, 32'hA5A50001, 1'b1, 5'd3, 32'h33, 1'b1, 1'b1, 1'b1, 5'd10, 32'hA5A50001, 32'h8);
    tbl[3]  = v(1'b0, 1'b1, 5'd3,  32'h44,       1'b1, 5'd3, 32'h55, 1'b1, 1'b1, 1'b1, 5'd3,  32'h44,       32'h0);
    tbl[4]  = v(1'b0, 1'b1, 5'd0,  32'h66,       1'b1, 5'd0, 32'h99, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0,        32'h0);
    tbl[5]  = v(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b0, 5'd0,  32'h0,        32'h0);
    tbl[6]  = v(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b0, 5'd0,  32'h0,        32'h0);
    tbl[7]  = v(1'b0, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 32'h0);
    tbl[8]  = v(1'b0, 1'b1, 5'd1,  32'h0,        1'b1, 5'd7, 32'h77, 1'b1, 1'b1, 1'b1, 5'd1,  32'h0,        32'h80);
    tbl[9]  = v(1'b0, 1'b1, 5'd2,  32'h2,        1'b1, 5'd8, 32'h88, 1'b1, 1'b1, 1'b1, 5'd2,  32'h2,        32'h180);
    tbl[10] = v(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd7,  32'h77,       32'h100);
    tbl[11] = v(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd8,  32'h88,       32'h0);
    tbl[12] = v(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b0, 5'd0,  32'h0,        32'h0);

    for (int i = 0; i < 13; i++) begin
      apply(tbl[i].r, tbl[i].pw, tbl[i].prw, tbl[i].pd, tbl[i].av, tbl[i].arw, tbl[i].ad);
      chk($sformatf("tbl%0d.ready", i), 32'(o_ready), 32'(tbl[i].e_ready));
      chk($sformatf("tbl%0d.regwr", i), 32'(o_regwr), 32'(tbl[i].e_regwr));
      if (tbl[i].e_bus) begin
        chk($sformatf("tbl%0d.rw", i), 32'(o_rw), 32'(tbl[i].e_rw));
        chk($sformatf("tbl%0d.busw", i), o_busw, tbl[i].e_busw);
      end
      chk($sformatf("tbl%0d.pend", i), o_pend, tbl[i].e_pend);
    end

    // Single aux write through an idle arbiter.
    step("a0", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) step("a_idle", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Fill the queue behind a continuous pipeline stream, then drain in order.
    for (int k = 0; k < 4; k++)
      step("b_fill", 1'b0, 1'b1, 5'd9, 32'h900 + 32'(k), 1'b1, 5'd11 + 5'(k), 32'hB0 + 32'(k));
    step("b_full", 1'b0, 1'b1, 5'd9, 32'h9FF, 1'b1, 5'd20, 32'hBAD);
    for (int i = 0; i < 6; i++) step("b_drain", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Queued write superseded by a later pipeline write to the same register.
    step("c_q7", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h70);
    step("c_p7", 1'b0, 1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 3; i++) step("c_idle", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Reset with entries queued.
    for (int k = 0; k < 3; k++)
      step("e_fill", 1'b0, 1'b1, 5'd4, 32'h40 + 32'(k), 1'b1, 5'd21 + 5'(k), 32'hE0 + 32'(k));
    step("e_rst", 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h6);
    for (int i = 0; i < 4; i++) step("e_idle", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    for (int n = 0; n < 400; n++) begin
      logic r, pw, av;
      logic [4:0] prw, arw;
      logic [31:0] pd, ad;
      r   = ($urandom_range(63) == 0);
      pw  = 1'($urandom_range(1));
      prw = 5'($urandom_range(7));
      pd  = $urandom;
      av  = ($urandom_range(9) < 6);
      arw = 5'($urandom_range(7));
      ad  = $urandom;
      step("rnd", r, pw, prw, pd, av, arw, ad);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Writer-side front end for the 32x32 register file write port (RegWr/RW/BusW, committed on negedge Clk).
- Merges two writeback sources into one write per cycle:
  - the in-order pipeline writeback, which has fixed priority and no backpressure;
  - a long-latency auxiliary source (mult/div, load-miss) with a valid/ready handshake, buffered in a small FIFO.
- Exports a pending-destination mask for the hazard unit.

Parameters:
- DEPTH, 4, auxiliary FIFO entries (power of two, 2..16)
- AW, 5, register address width
- DW, 32, data width

Ports:
- Clk  input  1  clock; all state updates on posedge
- Rst  input  1  synchronous active-high reset
- PipeWr  input  1  pipeline writeback request this cycle
- PipeRW  input  AW  pipeline destination register
- PipeBusW  input  DW  pipeline write data
- AuxValid  input  1  auxiliary result valid
- AuxRW  input  AW  auxiliary destination register
- AuxData  input  DW  auxiliary write data
- AuxReady  output  1  auxiliary source may transfer this cycle
- RegWr  output  1  register file write enable (registered)
- RW  output  AW  register file write address (registered)
- BusW  output  DW  register file write data (registered)
- PendMask  output  32  bit r set = a live queued auxiliary write targets register r

Behaviour:
- Interface: one clock (Clk); reset (Rst) is synchronous and active-high.
- Reset values:
  - RegWr=0, RW=0, BusW=0, PendMask=0, FIFO empty, all entries dead.
  - AuxReady=0 while Rst=1.
- Handshake:
  - AuxReady = !Rst && (count < DEPTH), based on count before this edge.
  - A transfer occurs when AuxValid && AuxReady.
  - Push and pop in the same cycle are allowed; a full FIFO never accepts, even if it pops that cycle.
- Register-0 rule: requests to register 0 are never forwarded.
  - PipeWr with PipeRW==0 is treated as idle.
  - An aux transfer with AuxRW==0 is accepted and discarded; it is never pushed.
- Output selection, registered, 1-cycle latency from request to RegWr:
  - PipeWr && PipeRW!=0: emit the pipeline write; the FIFO does not pop.
  - Else, FIFO non-empty: pop the head. Emit RegWr=1 if the head is live; if it is dead, RegWr=0 and the cycle is consumed.
  - Else RegWr=0. RW and BusW hold their previous values.
- WAW kill:
  - A pipeline write to register r != 0 marks every queued live entry with RW==r dead in the same cycle.
  - An aux entry pushed in the same cycle with AuxRW==r is pushed dead, because aux results count as older than a same-cycle pipeline write.
- PendMask: OR of decoded RW over live entries, registered. It updates one cycle after any push, pop or kill.
- Starvation: aux entries drain only on cycles with no pipeline write. No timeout.
- Reset mid-operation: all queued entries are discarded and no write is issued on the cycle after reset.
- Pointers wrap modulo DEPTH. Count width is $clog2(DEPTH+1).

Optional Feature:
- Macro: WB_AUX_BYPASS_EN.
- Defined: when the FIFO is empty, there is no pipeline write, and an aux transfer to a nonzero register occurs, the aux write goes straight to RegWr/RW/BusW at the next edge without being pushed. Latency drops from 2 cycles to 1, and PendMask is not set for it.
- Undefined: every aux write passes through the FIFO, with a minimum 2-cycle latency.

Decomposition:
- Shared package, wb_pkg:
  - constants REG_ZERO=5'd0, DEFAULT_WB_DEPTH=4;
  - typedef wb_entry_t {live, rw[AW], data[DW]}.
- One natural sub-module, wb_kill_fifo: circular FIFO with per-entry live bit and a kill-by-address port. The top holds the arbitration and output registers.

Test Plan:
- Reset then idle -> RegWr=0, PendMask=0, AuxReady=1 on the first cycle after Rst drops.
- Aux push RW=5, data 0xDEAD_BEEF, pipeline idle -> PendMask[5]=1 after 1 cycle; RegWr=1, RW=5, BusW=0xDEADBEEF 2 cycles after the push (1 cycle with WB_AUX_BYPASS_EN).
- Push 4 aux entries while PipeWr is held high to r=9 -> AuxReady=0 after the 4th push; no aux writes while PipeWr is high; after PipeWr drops, 4 consecutive aux writes in order.
- Queue RW=7, then pipeline write RW=7 value 0x11 -> RW=7/0x11 written; the queued entry later pops with RegWr=0; PendMask[7] clears.
- Same-cycle aux push RW=3 and pipeline write RW=3 -> only the pipeline write reaches the register file; PendMask[3] never sets.
- Aux push RW=0 and PipeWr with PipeRW=0 -> AuxReady handshake completes, RegWr stays 0, FIFO count unchanged; Rst asserted with 3 queued -> FIFO empty, no subsequent writes.
